// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the multi-cycle single-precision FPU: accepts one FP op,
// counts its fixed latency, strobes the write-back and raises hazard stalls.
module fpu_issue_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12,
    parameter int CMP_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_op,
    input  logic [4:0] issue_fd,
    output logic       issue_ready,
    input  logic       dep_valid,
    input  logic [4:0] dep_reg,
    input  logic       dep_fcc,
    input  logic       flush,
    output logic       fpu_start,
    output logic [2:0] fpu_op,
    output logic       fpu_abort,
    output logic       fpr_we,
    output logic [4:0] fpr_waddr,
    output logic       fcc_we,
    output logic       busy,
    output logic       stall
);

    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       fd_q, fd_d;
    logic             first_q, first_d;
    logic             raw_hz, fcc_hz, struct_hz;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: lat_of = CNT_W'(ADD_LAT);
            3'd2:       lat_of = CNT_W'(MUL_LAT);
            3'd3:       lat_of = CNT_W'(DIV_LAT);
            3'd7:       lat_of = CNT_W'(CMP_LAT);
            default:    lat_of = CNT_W'(1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            fd_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fd_q    <= fd_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fd_d      = fd_q;
        first_d   = 1'b0;
        fpu_abort = 1'b0;
        fpr_we    = 1'b0;
        fcc_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in IDLE only blocks this cycle's issue.
                if (issue_valid && !flush) begin
                    op_d    = issue_op;
                    fd_d    = issue_fd;
                    cnt_d   = lat_of(issue_op);
                    first_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (flush) begin
                    fpu_abort = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
                if (flush) begin
                    fpu_abort = 1'b1;
                end else begin
                    fpr_we = (op_q != OP_CMP);
                    fcc_we = (op_q == OP_CMP);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign fpu_start   = (state_q == EXEC) && first_q;
    assign fpu_op      = op_q;
    assign fpr_waddr   = fd_q;

    // Stall holds through WB since the register file commits at the end of it.
    assign raw_hz    = busy && dep_valid && (dep_reg == fd_q) && (op_q != OP_CMP);
    assign fcc_hz    = busy && dep_fcc && (op_q == OP_CMP);
    assign struct_hz = issue_valid && !issue_ready;
    assign stall     = raw_hz || fcc_hz || struct_hz;

endmodule
